// File: rtl/astro_target_engine.sv
// AstroBarrier game-state engine: bouncing target lanes, a clamped ship and a single bullet,
// with per-target hit tracking, a saturating score, round restart and registered pixel layer flags.
module astro_target_engine #(
  parameter int NUM_TARGETS = 4,
  parameter int X_MIN       = 10,
  parameter int X_MAX       = 612,
  parameter int T_STEP      = 2,
  parameter int T_HALF      = 10,
  parameter int ROW0_Y      = 100,
  parameter int ROW_PITCH   = 50,
  parameter int SHIP_INIT   = 400,
  parameter int SHIP_MIN    = 30,
  parameter int SHIP_MAX    = 610,
  parameter int SHIP_STEP   = 5,
  parameter int B_Y0        = 435,
  parameter int B_STEP      = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_fire,
  input  logic [9:0]             pix_x,
  input  logic [9:0]             pix_y,
  input  logic                   pix_valid,
  output logic [9:0]             ship_x,
  output logic [NUM_TARGETS-1:0] target_hit,
  output logic                   all_hit,
  output logic [7:0]             score,
  output logic                   bullet_active,
  output logic                   pix_ship,
  output logic                   pix_live,
  output logic                   pix_dead,
  output logic                   pix_bullet
);

  typedef enum logic [0:0] {PLAY = 1'b0, CLEARED = 1'b1} round_state_t;

  round_state_t           state_r;
  round_state_t           state_next_s;
  logic [9:0]             ship_x_r;
  logic [9:0]             ship_next_s;
  logic [9:0]             tgt_x_r [NUM_TARGETS];
  logic [NUM_TARGETS-1:0] tgt_dir_r;
  logic [NUM_TARGETS-1:0] hit_r;
  logic [NUM_TARGETS-1:0] hit_now_s;
  logic [7:0]             score_r;
  logic                   bullet_r;
  logic [9:0]             bx_r;
  logic [9:0]             by_r;
  logic                   all_hit_s;
  logic                   ship_pix_s;
  logic                   live_pix_s;
  logic                   dead_pix_s;
  logic                   bullet_pix_s;
  logic                   pix_ship_r;
  logic                   pix_live_r;
  logic                   pix_dead_r;
  logic                   pix_bullet_r;

  function automatic logic [9:0] init_x(input int idx);
    init_x = 10'(X_MIN + 2 * T_STEP * ((idx * (X_MAX - X_MIN)) / (2 * T_STEP * NUM_TARGETS)));
  endfunction

  function automatic logic [9:0] lane_y(input int idx);
    lane_y = 10'(ROW0_Y + idx * ROW_PITCH);
  endfunction

  // Signed 11-bit distance test so coordinates near zero never wrap
  function automatic logic near(input logic [9:0] a, input logic [9:0] b, input logic [10:0] half);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    near = (d <= $signed(half)) && (d >= -$signed(half));
  endfunction

  // Round state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= PLAY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Round transitions: clear on the tick landing the last hit, restart on fire
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      PLAY: begin
        if (tick && (hit_now_s != '0) && ((hit_r | hit_now_s) == {NUM_TARGETS{1'b1}})) begin
          state_next_s = CLEARED;
        end else begin
          state_next_s = PLAY;
        end
      end
      CLEARED: begin
        if (tick && btn_fire) begin
          state_next_s = PLAY;
        end else begin
          state_next_s = CLEARED;
        end
      end
      default: state_next_s = PLAY;
    endcase
  end

  // Round outputs
  always_comb begin
    all_hit_s = 1'b0;
    case (state_r)
      CLEARED: all_hit_s = 1'b1;
      default: all_hit_s = 1'b0;
    endcase
  end

  // Bullet hit test: only the lowest-index live target under the bullet is taken
  always_comb begin
    hit_now_s = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      hit_now_s[i] = bullet_r && (state_r == PLAY) && !hit_r[i] && (hit_now_s == '0) &&
                     near(bx_r, tgt_x_r[i], 11'(T_HALF)) && near(by_r, lane_y(i), 11'(T_HALF));
    end
  end

  // Ship move request with clamping; opposing buttons cancel
  always_comb begin
    ship_next_s = ship_x_r;
    if (btn_right && !btn_left) begin
      ship_next_s = (ship_x_r >= 10'(SHIP_MAX - SHIP_STEP)) ? 10'(SHIP_MAX) : ship_x_r + 10'(SHIP_STEP);
    end else if (btn_left && !btn_right) begin
      ship_next_s = (ship_x_r <= 10'(SHIP_MIN + SHIP_STEP)) ? 10'(SHIP_MIN) : ship_x_r - 10'(SHIP_STEP);
    end else begin
      ship_next_s = ship_x_r;
    end
  end

  // Game state update, one step per tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ship_x_r <= 10'(SHIP_INIT);
      hit_r    <= '0;
      score_r  <= 8'd0;
      bullet_r <= 1'b0;
      bx_r     <= 10'd0;
      by_r     <= 10'd0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
        tgt_x_r[i]   <= init_x(i);
        tgt_dir_r[i] <= ((i % 2) == 0);
      end
    end else if (tick) begin
      ship_x_r <= ship_next_s;
      if (state_r == PLAY) begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
          if (!hit_r[i]) begin
            if (tgt_dir_r[i]) begin
              if (tgt_x_r[i] == 10'(X_MAX)) begin
                tgt_dir_r[i] <= 1'b0;
                tgt_x_r[i]   <= tgt_x_r[i] - 10'(T_STEP);
              end else begin
                tgt_x_r[i]   <= tgt_x_r[i] + 10'(T_STEP);
              end
            end else begin
              if (tgt_x_r[i] == 10'(X_MIN)) begin
                tgt_dir_r[i] <= 1'b1;
                tgt_x_r[i]   <= tgt_x_r[i] + 10'(T_STEP);
              end else begin
                tgt_x_r[i]   <= tgt_x_r[i] - 10'(T_STEP);
              end
            end
          end
        end
        hit_r <= hit_r | hit_now_s;
        // A bullet retiring this tick takes priority over a new launch
        if (hit_now_s != '0) begin
          bullet_r <= 1'b0;
          if (score_r != 8'hFF) begin
            score_r <= score_r + 8'd1;
          end
        end else if (bullet_r) begin
          if (by_r < 10'(B_STEP)) begin
            bullet_r <= 1'b0;
          end else begin
            by_r <= by_r - 10'(B_STEP);
          end
        end else if (btn_fire) begin
          bullet_r <= 1'b1;
          bx_r     <= ship_x_r;
          by_r     <= 10'(B_Y0);
        end
      end else if (btn_fire) begin
        hit_r <= '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
          tgt_x_r[i]   <= init_x(i);
          tgt_dir_r[i] <= ((i % 2) == 0);
        end
      end
    end
  end

  // Pixel layer decode from the current registered state
  always_comb begin
    live_pix_s = 1'b0;
    dead_pix_s = 1'b0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      live_pix_s = live_pix_s | (!hit_r[i] && near(pix_x, tgt_x_r[i], 11'(T_HALF)) &&
                                 near(pix_y, lane_y(i), 11'(T_HALF)));
      dead_pix_s = dead_pix_s | (hit_r[i] && near(pix_x, tgt_x_r[i], 11'(T_HALF)) &&
                                 near(pix_y, lane_y(i), 11'(T_HALF)));
    end
    ship_pix_s   = near(pix_x, ship_x_r, 11'd30) && (pix_y >= 10'd448) && (pix_y <= 10'd511);
    bullet_pix_s = bullet_r && near(pix_x, bx_r, 11'd3) && near(pix_y, by_r, 11'd5);
  end

  // Pixel flag registers, gated by the display-area qualifier
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_ship_r   <= 1'b0;
      pix_live_r   <= 1'b0;
      pix_dead_r   <= 1'b0;
      pix_bullet_r <= 1'b0;
    end else begin
      pix_ship_r   <= pix_valid && ship_pix_s;
      pix_live_r   <= pix_valid && live_pix_s;
      pix_dead_r   <= pix_valid && dead_pix_s;
      pix_bullet_r <= pix_valid && bullet_pix_s;
    end
  end

  assign ship_x        = ship_x_r;
  assign target_hit    = hit_r;
  assign all_hit       = all_hit_s;
  assign score         = score_r;
  assign bullet_active = bullet_r;
  assign pix_ship      = pix_ship_r;
  assign pix_live      = pix_live_r;
  assign pix_dead      = pix_dead_r;
  assign pix_bullet    = pix_bullet_r;

endmodule

// File: tb/tb_astro_target_engine.sv
// Self-checking bench for astro_target_engine: a behavioural game model feeds a scoreboard
// queue on every tick and pixel probe; directed constants cover clamps, hits and restart.
module tb_astro_target_engine;
  localparam int NT = 4;
  localparam int X_MIN = 10, X_MAX = 612, T_STEP = 2, T_HALF = 10;
  localparam int ROW0_Y = 100, ROW_PITCH = 50;
  localparam int SHIP_INIT = 400, SHIP_MIN = 30, SHIP_MAX = 610, SHIP_STEP = 5;
  localparam int B_Y0 = 435, B_STEP = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic          btn_left = 1'b0, btn_right = 1'b0, btn_fire = 1'b0;
  logic [9:0]    pix_x = 10'd0, pix_y = 10'd0;
  logic          pix_valid = 1'b0;
  logic [9:0]    ship_x;
  logic [NT-1:0] target_hit;
  logic          all_hit;
  logic [7:0]    score;
  logic          bullet_active;
  logic          pix_ship, pix_live, pix_dead, pix_bullet;

  always #5 clk = ~clk;

  astro_target_engine #(
    .NUM_TARGETS(NT), .X_MIN(X_MIN), .X_MAX(X_MAX), .T_STEP(T_STEP), .T_HALF(T_HALF),
    .ROW0_Y(ROW0_Y), .ROW_PITCH(ROW_PITCH), .SHIP_INIT(SHIP_INIT), .SHIP_MIN(SHIP_MIN),
    .SHIP_MAX(SHIP_MAX), .SHIP_STEP(SHIP_STEP), .B_Y0(B_Y0), .B_STEP(B_STEP)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .ship_x(ship_x), .target_hit(target_hit), .all_hit(all_hit), .score(score),
    .bullet_active(bullet_active),
    .pix_ship(pix_ship), .pix_live(pix_live), .pix_dead(pix_dead), .pix_bullet(pix_bullet)
  );

  typedef struct {
    string       tag;
    logic [23:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Game model
  int         m_ship;
  int         m_x[NT];
  bit         m_dir[NT];
  bit [NT-1:0] m_hit;
  int         m_score;
  bit         m_clr;
  bit         m_bact;
  int         m_bx, m_by;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int init_x(input int i);
    return X_MIN + 2 * T_STEP * ((i * (X_MAX - X_MIN)) / (2 * T_STEP * NT));
  endfunction

  function automatic int lane_y(input int i);
    return ROW0_Y + i * ROW_PITCH;
  endfunction

  function automatic int nxt_x(input int x, input bit d);
    if (d) return (x == X_MAX) ? x - T_STEP : x + T_STEP;
    return (x == X_MIN) ? x + T_STEP : x - T_STEP;
  endfunction

  function automatic bit nxt_d(input int x, input bit d);
    if (d) return (x == X_MAX) ? 1'b0 : 1'b1;
    return (x == X_MIN) ? 1'b1 : 1'b0;
  endfunction

  task automatic model_reset();
    m_ship = SHIP_INIT; m_hit = '0; m_score = 0; m_clr = 1'b0;
    m_bact = 1'b0; m_bx = 0; m_by = 0;
    for (int i = 0; i < NT; i++) begin
      m_x[i] = init_x(i);
      m_dir[i] = ((i % 2) == 0);
    end
  endtask

  task automatic model_tick(input bit l, input bit r, input bit f);
    int ship0;
    bit [NT-1:0] hit0;
    int hi;
    ship0 = m_ship; hit0 = m_hit; hi = -1;
    if (r && !l) m_ship = (m_ship + SHIP_STEP > SHIP_MAX) ? SHIP_MAX : m_ship + SHIP_STEP;
    else if (l && !r) m_ship = (m_ship - SHIP_STEP < SHIP_MIN) ? SHIP_MIN : m_ship - SHIP_STEP;
    if (!m_clr) begin
      if (m_bact) begin
        for (int i = 0; i < NT; i++)
          if (hi < 0 && !hit0[i] && iabs(m_bx - m_x[i]) <= T_HALF && iabs(m_by - lane_y(i)) <= T_HALF)
            hi = i;
        if (hi >= 0) begin
          m_hit[hi] = 1'b1;
          if (m_score < 255) m_score++;
          m_bact = 1'b0;
        end else if (m_by < B_STEP) m_bact = 1'b0;
        else m_by -= B_STEP;
      end else if (f) begin
        m_bact = 1'b1; m_bx = ship0; m_by = B_Y0;
      end
      for (int i = 0; i < NT; i++)
        if (!hit0[i]) begin
          bit d0;
          d0 = m_dir[i];
          m_dir[i] = nxt_d(m_x[i], d0);
          m_x[i] = nxt_x(m_x[i], d0);
        end
      if (m_hit == '1) m_clr = 1'b1;
    end else if (f) begin
      m_clr = 1'b0; m_hit = '0;
      for (int i = 0; i < NT; i++) begin
        m_x[i] = init_x(i);
        m_dir[i] = ((i % 2) == 0);
      end
    end
  endtask

  function automatic logic [23:0] pack_state();
    return {10'(m_ship), m_hit, m_clr, 8'(m_score), m_bact};
  endfunction

  function automatic logic [23:0] obs_state();
    return {ship_x, target_hit, all_hit, score, bullet_active};
  endfunction

  function automatic logic [23:0] pix_exp(input int px, input int py, input bit pv);
    bit s, lv, dd, bl;
    s = pv && iabs(px - m_ship) <= 30 && py >= 448 && py <= 511;
    lv = 1'b0; dd = 1'b0;
    for (int i = 0; i < NT; i++)
      if (pv && iabs(px - m_x[i]) <= T_HALF && iabs(py - lane_y(i)) <= T_HALF) begin
        if (m_hit[i]) dd = 1'b1;
        else lv = 1'b1;
      end
    bl = pv && m_bact && iabs(px - m_bx) <= 3 && iabs(py - m_by) <= 5;
    return {20'd0, s, lv, dd, bl};
  endfunction

  task automatic compare(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [23:0] exp);
    sb_t e;
    e.tag = tag; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [23:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $error("FAIL scoreboard_empty: observed %0h expected an entry", obs);
    end else begin
      e = sb_q.pop_front();
      compare(e.tag, obs, e.exp);
    end
  endtask

  task automatic do_tick(input bit l, input bit r, input bit f, input string tag);
    btn_left = l; btn_right = r; btn_fire = f; tick = 1'b1;
    model_tick(l, r, f);
    push_exp(tag, pack_state());
    @(posedge clk); #1;
    tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0;
    pop_check(obs_state());
    @(posedge clk); #1;
  endtask

  task automatic probe(input int px, input int py, input bit pv, input string tag);
    pix_x = 10'(px); pix_y = 10'(py); pix_valid = pv;
    push_exp(tag, pix_exp(px, py, pv));
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pop_check({20'd0, pix_ship, pix_live, pix_dead, pix_bullet});
  endtask

  // Box edges of every target pin its X to the exact model position
  task automatic probe_targets(input string tag);
    int offs[4];
    offs = '{-11, -10, 10, 11};
    for (int i = 0; i < NT; i++) begin
      for (int k = 0; k < 4; k++)
        if (m_x[i] + offs[k] >= 0) probe(m_x[i] + offs[k], lane_y(i), 1'b1, tag);
      probe(m_x[i], lane_y(i) + 10, 1'b1, tag);
      probe(m_x[i], lane_y(i) + 11, 1'b1, tag);
    end
  endtask

  function automatic int predict_x(input int t, input int steps);
    int x; bit d, d0;
    x = m_x[t]; d = m_dir[t];
    for (int k = 0; k < steps; k++) begin
      d0 = d; d = nxt_d(x, d0); x = nxt_x(x, d0);
    end
    return x;
  endfunction

  // Would a bullet fired now from ship X s hit target t (assuming nothing else intercepts)?
  function automatic bit will_hit(input int t, input int s);
    int x; bit d, d0;
    x = m_x[t]; d = m_dir[t];
    for (int k = 1; k <= 44; k++) begin
      d0 = d; d = nxt_d(x, d0); x = nxt_x(x, d0);
      if (iabs(B_Y0 - B_STEP * (k - 1) - lane_y(t)) <= T_HALF && iabs(s - x) <= T_HALF) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic aim_shot(input int t, input logic [NT-1:0] want_hit, input int want_score);
    int budget, goal, kmid, fly;
    budget = 0; fly = 0;
    kmid = (B_Y0 - lane_y(t)) / B_STEP + 1;
    while (!will_hit(t, m_ship) && budget < 1000) begin
      goal = predict_x(t, kmid);
      if (m_ship < goal - 2) do_tick(1'b0, 1'b1, 1'b0, "aim_move");
      else if (m_ship > goal + 2) do_tick(1'b1, 1'b0, 1'b0, "aim_move");
      else do_tick(1'b0, 1'b0, 1'b0, "aim_wait");
      budget++;
    end
    compare("aim_budget", 24'(budget < 1000), 24'd1);
    do_tick(1'b0, 1'b0, 1'b1, "aim_fire");
    compare("aim_launch", 24'(bullet_active), 24'd1);
    while (m_bact && fly < 60) begin
      do_tick(1'b0, 1'b0, 1'b0, "aim_fly");
      fly++;
    end
    compare("shot_hit_vec", 24'(target_hit), 24'(want_hit));
    compare("shot_score", 24'(score), 24'(want_score));
    compare("shot_bullet_idle", 24'(bullet_active), 24'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit any;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    push_exp("reset_state", pack_state());
    pop_check(obs_state());
    compare("reset_pix", 24'({pix_ship, pix_live, pix_dead, pix_bullet}), 24'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // First tick: ship unchanged, targets step in their start directions
    do_tick(1'b0, 1'b0, 1'b0, "tick1");
    probe_targets("init_pos");
    probe(400, 460, 1'b1, "ship_pix_in");
    probe(430, 448, 1'b1, "ship_pix_edge");
    probe(431, 448, 1'b1, "ship_pix_out_x");
    probe(400, 447, 1'b1, "ship_pix_out_y");
    probe(400, 460, 1'b0, "ship_pix_gated");
    probe(m_x[0], lane_y(0), 1'b0, "live_pix_gated");

    // Ship clamps
    repeat (50) do_tick(1'b0, 1'b1, 1'b0, "ship_right");
    compare("ship_clamp_hi", 24'(ship_x), 24'd610);
    repeat (3) do_tick(1'b1, 1'b1, 1'b0, "ship_both");
    compare("ship_both_hold", 24'(ship_x), 24'd610);
    repeat (130) do_tick(1'b1, 1'b0, 1'b0, "ship_left");
    compare("ship_clamp_lo", 24'(ship_x), 24'd30);

    // Bounce at X_MAX for target 0
    n = 0;
    while (!(m_x[0] == X_MAX && m_dir[0]) && n < 700) begin
      do_tick(1'b0, 1'b0, 1'b0, "run_to_max");
      n++;
    end
    compare("reach_xmax", 24'(n < 700), 24'd1);
    probe_targets("at_xmax");
    do_tick(1'b0, 1'b0, 1'b0, "bounce_max");
    compare("bounce_max_model", 24'(m_x[0]), 24'd610);
    probe_targets("after_xmax");

    // Bounce at X_MIN for whichever target arrives first
    n = 0;
    any = 1'b0;
    while (!any && n < 700) begin
      for (int i = 0; i < NT; i++) if (m_x[i] == X_MIN && !m_dir[i]) any = 1'b1;
      if (!any) begin
        do_tick(1'b0, 1'b0, 1'b0, "run_to_min");
        n++;
      end
    end
    compare("reach_xmin", 24'(n < 700), 24'd1);
    probe_targets("at_xmin");
    do_tick(1'b0, 1'b0, 1'b0, "bounce_min");
    probe_targets("after_xmin");

    // Shoot lanes bottom-up so no lower lane can intercept
    aim_shot(3, 4'b1000, 1);
    probe_targets("one_dead");
    aim_shot(2, 4'b1100, 2);
    aim_shot(1, 4'b1110, 3);
    aim_shot(0, 4'b1111, 4);
    compare("all_hit_set", 24'(all_hit), 24'd1);

    // Cleared: targets frozen, ship still moves, fire restarts without launching
    do_tick(1'b0, 1'b1, 1'b0, "cleared_move");
    probe_targets("cleared_frozen");
    do_tick(1'b0, 1'b0, 1'b1, "restart");
    compare("restart_hit_vec", 24'(target_hit), 24'd0);
    compare("restart_score", 24'(score), 24'd4);
    compare("restart_bullet", 24'(bullet_active), 24'd0);
    compare("restart_all_hit", 24'(all_hit), 24'd0);
    probe_targets("restart_pos");

    // Clean miss: bullet climbs to y=5, retires, and cannot relaunch on that tick
    n = 0;
    any = 1'b1;
    while (any && n < 800) begin
      any = 1'b0;
      for (int i = 0; i < NT; i++) if (will_hit(i, m_ship)) any = 1'b1;
      if (any) begin
        do_tick(1'b0, 1'b0, 1'b0, "miss_wait");
        n++;
      end
    end
    compare("miss_slot", 24'(n < 800), 24'd1);
    do_tick(1'b0, 1'b0, 1'b1, "miss_fire");
    probe(m_bx + 3, m_by + 5, 1'b1, "bullet_pix_edge");
    probe(m_bx + 4, m_by, 1'b1, "bullet_pix_out");
    n = 0;
    while (m_bact && m_by != 5 && n < 60) begin
      do_tick(1'b0, 1'b0, 1'b0, "miss_fly");
      n++;
    end
    compare("bullet_top_y", 24'(m_by), 24'd5);
    probe(m_bx, 0, 1'b1, "bullet_pix_top");
    do_tick(1'b0, 1'b0, 1'b1, "retire_hold_fire");
    compare("retire_no_relaunch", 24'(bullet_active), 24'd0);
    do_tick(1'b0, 1'b0, 1'b1, "relaunch");
    compare("relaunch", 24'(bullet_active), 24'd1);

    // Asynchronous reset mid-flight
    probe(m_ship, 460, 1'b1, "pre_reset_ship_pix");
    reset = 1'b1;
    #1;
    model_reset();
    push_exp("async_reset_state", pack_state());
    pop_check(obs_state());
    compare("async_reset_pix", 24'({pix_ship, pix_live, pix_dead, pix_bullet}), 24'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_tick(1'b0, 1'b0, 1'b0, "post_reset_tick");
    probe_targets("post_reset_pos");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
